// File: rtl/scan_pkg.sv
// Shared types and constants for the scan-chain responder.
// Holds the FSM encoding, CRC-16-CCITT parameters and the serial CRC step.
package scan_pkg;

    typedef logic [1:0] scan_state_t;

    localparam scan_state_t ST_IDLE = 2'd0;
    localparam scan_state_t ST_KEY  = 2'd1;
    localparam scan_state_t ST_SCAN = 2'd2;
    localparam scan_state_t ST_LOCK = 2'd3;

    localparam logic [15:0] CRC16_POLY  = 16'h1021;
    localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
    localparam logic [15:0] DEFAULT_KEY = 16'hA5C3;

    function automatic logic [15:0] crc16_step(
        input logic [15:0] s,
        input logic        b
    );
        logic fb;
        fb = s[15] ^ b;
        return {s[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/crc16_misr.sv
// Serial CRC-16-CCITT signature register.
// Load-init has priority over the shift enable.
module crc16_misr
    import scan_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load_init,
    input  logic        din,
    output logic [15:0] sig
);

    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= CRC16_INIT;
        end else if (load_init) begin
            sig <= CRC16_INIT;
        end else if (en) begin
            sig <= crc16_step(sig, din);
        end
    end

endmodule

// File: rtl/scan_chain_responder.sv
// Tester-side scan access responder: key unlock FSM, chain-test
// shift register and CRC-16 signature of the unloaded stream.
module scan_chain_responder
    import scan_pkg::*;
#(
    parameter int                KEY_W     = 16,
    parameter logic [KEY_W-1:0]  KEY       = KEY_W'(DEFAULT_KEY),
    parameter int                CHAIN_LEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tst,
    input  logic        scl_rise,
    input  logic        sda,
    input  logic        scan_en_pin,
    input  logic        scan_in_pin,
    input  logic        scan_shift,
    output logic        test_mode,
    output logic        scan_en,
    output logic        scan_out,
    output logic [15:0] sig,
    output logic        sig_vld,
    output logic        key_err
);

    localparam int BW = $clog2(KEY_W + 1);
    localparam int SW = $clog2(CHAIN_LEN + 1);
    localparam logic [BW-1:0] KEY_LAST   = BW'(KEY_W - 1);
    localparam logic [SW-1:0] SHIFT_LAST = SW'(CHAIN_LEN - 1);

    scan_state_t          state;
    logic                 tst_q;
    logic [KEY_W-2:0]     key_sr;
    logic [BW-1:0]        bit_cnt;
    logic [CHAIN_LEN-1:0] chain;
    logic [SW-1:0]        shift_cnt;
    logic                 sig_vld_r;

    logic [KEY_W-1:0] key_next;
    logic             key_done;
    logic             scan_go;
    logic             misr_load;

    // Only KEY_W-1 history bits are kept; the incoming bit completes the key.
    assign key_next  = {key_sr, sda};
    assign key_done  = (state == ST_KEY) && tst && scl_rise
                       && (bit_cnt == KEY_LAST);
    assign misr_load = key_done && (key_next == KEY);
    assign scan_go   = (state == ST_SCAN) && tst
                       && scan_shift && scan_en_pin;

    crc16_misr u_misr (
        .clk       (clk),
        .rst       (rst),
        .en        (scan_go),
        .load_init (misr_load),
        .din       (chain[CHAIN_LEN-1]),
        .sig       (sig)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tst_q     <= 1'b0;
            key_sr    <= '0;
            bit_cnt   <= '0;
            chain     <= '0;
            shift_cnt <= '0;
            sig_vld_r <= 1'b0;
        end else begin
            tst_q     <= tst;
            sig_vld_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tst && !tst_q) begin
                        state   <= ST_KEY;
                        key_sr  <= '0;
                        bit_cnt <= '0;
                    end
                end
                ST_KEY: begin
                    if (!tst) begin
                        state <= ST_IDLE;
                    end else if (scl_rise) begin
                        key_sr  <= key_next[KEY_W-2:0];
                        bit_cnt <= bit_cnt + 1'b1;
                        if (key_done) begin
                            state     <= (key_next == KEY) ? ST_SCAN : ST_LOCK;
                            shift_cnt <= '0;
                        end
                    end
                end
                ST_SCAN: begin
                    if (!tst) begin
                        state <= ST_IDLE;
                    end else if (scan_go) begin
                        chain <= {chain[CHAIN_LEN-2:0], scan_in_pin};
                        if (shift_cnt == SHIFT_LAST) begin
                            shift_cnt <= '0;
                            sig_vld_r <= 1'b1;
                        end else begin
                            shift_cnt <= shift_cnt + 1'b1;
                        end
                    end
                end
                ST_LOCK: begin
                    state <= ST_LOCK;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign test_mode = (state == ST_SCAN);
    assign key_err   = (state == ST_LOCK);
    assign scan_en   = scan_en_pin & test_mode;
    assign scan_out  = chain[CHAIN_LEN-1];
    assign sig_vld   = sig_vld_r;

endmodule

// File: doc/scan_chain_responder.md
# scan_chain_responder

On-chip digital responder for tester-driven scan access on the 1127 chip. Decodes a serial unlock key presented on TST/SCL/SDA, enters scan test mode, and services a dedicated chain-test shift register with a CRC-16 signature register. It is the DUT-side end of the ATPG chain protocol that tester patterns drive, and sits between the pad-sync logic and the core test-mode muxes.

## Interface
Parameters:
- KEY_W, 16, unlock key width
- KEY, 16'hA5C3, unlock key value, MSB first
- CHAIN_LEN, 32, chain-test register length (≥2)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- tst  in  1  TST pin, already synchronized to clk
- scl_rise  in  1  one-cycle pulse per synchronized SCL rising edge
- sda  in  1  SDA pin, synchronized; sampled on scl_rise
- scan_en_pin  in  1  tester scan-enable (GPIO1), synchronized
- scan_in_pin  in  1  tester scan data (GPIO2), synchronized
- scan_shift  in  1  one-cycle shift strobe from tester clock edge detect
- test_mode  out  1  high only in SCAN state
- scan_en  out  1  scan_en_pin gated by test_mode
- scan_out  out  1  chain MSB, to GPIO3 mux
- sig  out  16  CRC-16 signature of scan_out stream
- sig_vld  out  1  one-cycle pulse per completed chain unload
- key_err  out  1  sticky wrong-key flag

## Operation
- FSM states: IDLE, KEY, SCAN, LOCK.
- IDLE: tst rising (0 last cycle, 1 now) → KEY; clear key shift register and bit counter.
- KEY: each scl_rise shifts sda into key_sr LSB (MSB-first overall), bit_cnt++. tst low → IDLE (abort, no error). After KEY_W-th bit: key_sr==KEY → SCAN, else → LOCK.
- SCAN: test_mode=1. On scan_shift with scan_en_pin=1: chain <= {chain[CHAIN_LEN-2:0], scan_in_pin}; MISR updates with the outgoing chain MSB; shift_cnt++. On shift_cnt reaching CHAIN_LEN: sig_vld pulse, shift_cnt wraps to 0, MISR not reset. scan_shift with scan_en_pin=0 ignored (capture cycle; no state change). tst low → IDLE.
- LOCK: key_err=1, test_mode=0; exits only on rst (brute-force protection).
- MISR: CRC-16-CCITT, poly x^16+x^12+x^5+1, shift-left, feedback = sig[15]^bit; set to 16'hFFFF on every SCAN entry.
- Chain register retains contents across SCAN exit/re-entry; cleared only by rst.

## Timing
- Reset values: test_mode=0, scan_en=0, scan_out=0, sig=16'hFFFF, sig_vld=0, key_err=0; chain=0, state=IDLE.
- test_mode rises the cycle after the clock that samples the final key bit; falls the cycle after tst is seen low.
- scan_out registered: reflects new chain MSB the cycle after scan_shift.
- sig and sig_vld update the cycle after the CHAIN_LEN-th shift strobe.
- Same-cycle tst low and scl_rise/scan_shift: tst low wins, strobe discarded.
- scl_rise outside KEY and scan_shift outside SCAN ignored.
- rst mid-operation: all state to reset values next cycle, including LOCK exit.

## Structure
- Shared package (scan_pkg): state enum, CRC16_POLY, CRC16_INIT, default KEY.
- One sub-module: crc16_misr (1-bit serial CRC update, enable, load-init).
- FSM, key shifter, chain register and counters in the top module.

## Test plan
- Key 0xA5C3 on 16 scl_rise strobes with tst high → test_mode=1 one cycle after 16th bit; key_err=0.
- Key 0xA5C2 → LOCK, key_err=1; re-sending 0xA5C3 after tst toggle leaves test_mode=0 until rst.
- tst drops after 8 key bits → IDLE, key_err=0; full correct key afterward enters SCAN.
- In SCAN, shift 0xDEADBEEF then 32 zeros → scan_out stream shows 32 zeros then 0xDEADBEEF MSB-first; sig_vld pulses after shifts 32 and 64; sig matches reference CRC model.
- scan_shift with scan_en_pin=0 between shifts → chain, shift_cnt, sig unchanged.
- rst asserted at shift 17 → all outputs reset values next cycle; sig=16'hFFFF, chain=0.
